// File: rtl/sframer.sv
// sframer: fixed-length packet framer (header, payload, optional sum trailer under SFRAMER_CHECKSUM_EN)
module sframer #(
  parameter int         PACKET_WORDS = 16,
  parameter logic [7:0] SYNC         = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] receiver_data,
  input  logic        receiver_valid,
  output logic        receiver_ready,
  output logic [31:0] sender_data,
  output logic        sender_valid,
  input  logic        sender_ready,
  output logic        sender_last,
  output logic        busy
);
  localparam logic [15:0] PW    = 16'(PACKET_WORDS);
  localparam logic [15:0] FINAL = 16'(PACKET_WORDS - 1);
`ifdef SFRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;
  localparam state_t TAIL = TRAILER;
`else
  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
  localparam state_t TAIL = IDLE;
`endif
  state_t state, state_n;
  logic [7:0] seq;
  logic [15:0] count;
  logic slot_free, hdr_go, accept, final_w, pkt_end, load, last_n;
  logic [31:0] data_n;
`ifdef SFRAMER_CHECKSUM_EN
  logic [31:0] sum;
  logic trl_go;
  assign trl_go = state == TRAILER && slot_free;
`endif
  assign slot_free = !sender_valid || sender_ready;
  assign receiver_ready = reset && state == PAYLOAD && slot_free;
  assign hdr_go = state == IDLE && receiver_valid && slot_free;
  assign accept = receiver_valid && receiver_ready;
  assign final_w = count == FINAL;
  assign busy = reset && (state != IDLE || hdr_go);
  // next state, what to load into the output slot and when the packet closes
  always_comb begin
`ifdef SFRAMER_CHECKSUM_EN
    pkt_end = trl_go;
    last_n = trl_go;
    load = hdr_go || accept || trl_go;
    data_n = hdr_go ? {SYNC, seq, PW} : trl_go ? sum : receiver_data;
`else
    pkt_end = accept && final_w;
    last_n = pkt_end;
    load = hdr_go || accept;
    data_n = hdr_go ? {SYNC, seq, PW} : receiver_data;
`endif
    state_n = hdr_go ? PAYLOAD : accept && final_w ? TAIL : pkt_end ? IDLE : state;
  end
  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // output slot and packet bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      sender_data <= '0;
      sender_valid <= 1'b0;
      sender_last <= 1'b0;
      seq <= '0;
      count <= '0;
`ifdef SFRAMER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      if (slot_free) sender_valid <= load;
      if (load) begin
        sender_data <= data_n;
        sender_last <= last_n;
      end
      if (hdr_go) count <= '0;
      else if (accept) count <= count + 16'd1;
      if (pkt_end) seq <= seq + 8'd1;
`ifdef SFRAMER_CHECKSUM_EN
      if (hdr_go) sum <= '0;
      else if (accept) sum <= sum + receiver_data;
`endif
    end
  end
endmodule

// File: tb/tb_sframer.sv
// tb_sframer: scoreboard bench for sframer with PACKET_WORDS=4 and PACKET_WORDS=1 instances
module tb_sframer;
`ifdef SFRAMER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clock = 0, reset = 0, ch = 0, rv = 0, sr = 1;
  logic [31:0] rd = 0;
  logic rv0, rv1, sr0, sr1, rr0, rr1, sv0, sv1, sl0, sl1, bz0, bz1;
  logic [31:0] sd0, sd1, sd;
  logic rr, sv, sl, bz;
  int total = 0, bad = 0;
  logic [31:0] inq[$];
  logic [32:0] expq[$];
  logic [7:0] seq = 0;
  logic [32:0] hd;
  int first, lastv, nv, nb;

  always #5 clock = ~clock;

  assign rv0 = rv && !ch;
  assign rv1 = rv && ch;
  assign sr0 = ch ? 1'b1 : sr;
  assign sr1 = ch ? sr : 1'b1;
  assign rr = ch ? rr1 : rr0;
  assign sv = ch ? sv1 : sv0;
  assign sd = ch ? sd1 : sd0;
  assign sl = ch ? sl1 : sl0;
  assign bz = ch ? bz1 : bz0;

  sframer #(.PACKET_WORDS(4)) u4 (
    .clock(clock), .reset(reset), .receiver_data(rd), .receiver_valid(rv0),
    .receiver_ready(rr0), .sender_data(sd0), .sender_valid(sv0),
    .sender_ready(sr0), .sender_last(sl0), .busy(bz0));
  sframer #(.PACKET_WORDS(1)) u1 (
    .clock(clock), .reset(reset), .receiver_data(rd), .receiver_valid(rv1),
    .receiver_ready(rr1), .sender_data(sd1), .sender_valid(sv1),
    .sender_ready(sr1), .sender_last(sl1), .busy(bz1));

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // expected packet: header with current seq, payload (last on final word unless a trailer follows), trailer sum
  task automatic push_pkt(input int pw, input int kind, input logic [31:0] base);
    logic [31:0] w, s;
    logic lb;
    s = 0;
    expq.push_back({1'b0, 8'hA5, seq, 16'(pw)});
    for (int i = 0; i < pw; i++) begin
      w = kind == 1 ? $urandom : kind == 2 ? (i == 0 ? 32'hFFFFFFFF : i == 1 ? 32'd2 : 32'd0) : base + 32'(i);
      s += w;
      inq.push_back(w);
      lb = CK == 0 && i == pw - 1;
      expq.push_back({lb, w});
    end
`ifdef SFRAMER_CHECKSUM_EN
    expq.push_back({1'b1, s});
`endif
    seq++;
  endtask

  task automatic cyc(input bit v, input bit r, input bit rs);
    @(negedge clock);
    reset = rs;
    rv = v && inq.size() > 0;
    rd = rv ? inq[0] : $urandom;
    sr = r;
    #1;
    if (rv && rr) void'(inq.pop_front());
    if (sv && sr) begin
      if (expq.size() == 0) chk("extra", 33'(sv), 33'd0);
      else begin
        chk("word", {sl, sd}, expq[0]);
        void'(expq.pop_front());
      end
    end
  endtask

  task automatic drain(input int lim, input bit rnd);
    int k;
    k = 0;
    while ((inq.size() > 0 || expq.size() > 0) && k < lim) begin
      cyc(rnd ? $urandom_range(0, 3) != 0 : 1'b1, rnd ? $urandom_range(0, 3) != 0 : 1'b1, 1'b1);
      k++;
    end
    chk("drain", 33'(inq.size() + expq.size()), 33'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("rst_valid", 33'(sv), 33'd0);
    chk("rst_last", 33'(sl), 33'd0);
    chk("rst_data", 33'(sd), 33'd0);
    chk("rst_busy", 33'(bz), 33'd0);
    chk("rst_ready", 33'(rr), 33'd0);

    push_pkt(4, 0, 32'd1);
    first = -1; lastv = 0; nv = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1);
      if (sv) begin
        if (first < 0) first = i;
        lastv = i;
        nv++;
      end
      if (bz) nb++;
    end
    chk("t1_vcnt", 33'(nv), 33'(5 + CK));
    chk("t1_span", 33'(lastv - first + 1), 33'(nv));
    chk("t1_busy", 33'(nb), 33'(5 + CK));
    chk("t1_left", 33'(inq.size() + expq.size()), 33'd0);

    push_pkt(4, 0, 32'd5);
    drain(50, 0);

    push_pkt(4, 1, 32'd0);
    repeat (3) cyc(1, 1, 1);
    cyc(1, 0, 1);
    hd = {sl, sd};
    chk("hold_v", 33'(sv), 33'd1);
    chk("hold_rr", 33'(rr), 33'd0);
    repeat (3) begin
      cyc(1, 0, 1);
      chk("hold_word", {sl, sd}, hd);
      chk("hold_rr", 33'(rr), 33'd0);
    end
    drain(50, 0);

    push_pkt(4, 2, 32'd0);
    drain(50, 0);

    repeat (6) push_pkt(4, 1, 32'd0);
    drain(2000, 1);

    push_pkt(4, 1, 32'd0);
    repeat (3) cyc(1, 1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("abort_valid", 33'(sv), 33'd0);
    chk("abort_busy", 33'(bz), 33'd0);
    chk("abort_data", 33'(sd), 33'd0);
    inq.delete();
    expq.delete();
    seq = 0;
    push_pkt(4, 1, 32'd0);
    drain(50, 0);

    ch = 1;
    seq = 0;
    repeat (257) push_pkt(1, 1, 32'd0);
    drain(1500, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
